// File: rtl/coords_frame_buffer_if.sv
// Keypoint capture and Nios coords-RAM bus for coords_frame_buffer.
// Signals:
//   pt_*                   keypoint stream from the camera pipeline
//   coords_ram_read_addr   Nios read address
//   coords_ram_read_data   registered read data back to the Nios
//   coords_ram_write_addr  Nios write address (level-sampled)
//   coords_ram_write_data  Nios write data (level-sampled)
//   frame_done             one-cycle pulse on each bank swap
// Modports: master = pipeline/Nios side, slave = the frame buffer.
interface coords_frame_buffer_if #(
    parameter int unsigned COORD_W = 11
);
    logic               pt_frame_start;
    logic               pt_valid;
    logic [4:0]         pt_idx;
    logic [COORD_W-1:0] pt_x;
    logic [COORD_W-1:0] pt_y;
    logic               pt_frame_end;
    logic [4:0]         coords_ram_read_addr;
    logic [31:0]        coords_ram_read_data;
    logic [4:0]         coords_ram_write_addr;
    logic [31:0]        coords_ram_write_data;
    logic               frame_done;

    modport master (
        output pt_frame_start, pt_valid, pt_idx, pt_x, pt_y, pt_frame_end,
        output coords_ram_read_addr, coords_ram_write_addr, coords_ram_write_data,
        input  coords_ram_read_data, frame_done
    );

    modport slave (
        input  pt_frame_start, pt_valid, pt_idx, pt_x, pt_y, pt_frame_end,
        input  coords_ram_read_addr, coords_ram_write_addr, coords_ram_write_data,
        output coords_ram_read_data, frame_done
    );
endinterface

// File: rtl/coords_frame_buffer.sv
// Double-buffered keypoint store. Points of the frame being captured land in a
// shadow bank; on frame end the banks swap so the Nios always reads one
// coherent frame.
// Ports:
//   clk_clk      system clock, rising edge
//   reset_reset  synchronous active-high reset
//   bus          coords_frame_buffer_if slave (keypoint stream + Nios bus)
// Read map: 0..NUM_POINTS-1 visible words, 30 {frame_count, valid_mask},
//   31 {sticky, ctrl}, everything else 0. Write to 31 sets ctrl.
module coords_frame_buffer #(
    parameter int unsigned NUM_POINTS = 16,
    parameter int unsigned COORD_W    = 11
) (
    input logic                  clk_clk,
    input logic                  reset_reset,
    coords_frame_buffer_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StCapture} state_e;

    state_e                 state_q, state_d;
    logic                   vis_sel_q, vis_sel_d;
    logic [NUM_POINTS-1:0]  mask_q [2];
    logic [NUM_POINTS-1:0]  mask_d [2];
    // {y, x} per slot; validity lives only in the mask, so no reset needed here
    logic [2*COORD_W-1:0]   coord_q [2][NUM_POINTS];
    logic [2*COORD_W-1:0]   coord_d [2][NUM_POINTS];
    logic [15:0]            frame_count_q, frame_count_d;
    logic [3:0]             ctrl_q, ctrl_d;
    logic [3:0]             sticky_q, sticky_d;
    logic [31:0]            read_data_q, read_data_d;
    logic                   frame_done_q, frame_done_d;

    logic        shadow;
    logic        in_range;
    logic        capturing;
    logic        do_end;
    logic        do_swap;
    logic        rec;
    logic [3:0]  sticky_set;
    logic [15:0] vis_mask16;
    logic        unused_write_data;

    assign unused_write_data = ^bus.coords_ram_write_data[31:4];

    always_comb begin
        shadow    = ~vis_sel_q;
        in_range  = bus.pt_idx < 5'(NUM_POINTS);
        capturing = (state_q == StCapture);
        do_end    = capturing && bus.pt_frame_end;
        do_swap   = do_end && !ctrl_q[0];
        // A start in IDLE opens the frame in time to accept a same-cycle point
        rec       = bus.pt_valid && in_range && (capturing || bus.pt_frame_start);

        state_d       = state_q;
        vis_sel_d     = vis_sel_q;
        mask_d        = mask_q;
        coord_d       = coord_q;
        frame_count_d = frame_count_q;
        ctrl_d        = ctrl_q;
        sticky_set    = '0;

        if (bus.coords_ram_write_addr == 5'd31) begin
            ctrl_d = bus.coords_ram_write_data[3:0];
        end

        // A start not paired with an end clears the shadow before the point lands
        if (bus.pt_frame_start && !do_end) begin
            mask_d[shadow] = '0;
        end

        // Recorded into the current shadow, i.e. the bank being swapped on an end
        if (rec) begin
            for (int i = 0; i < NUM_POINTS; i++) begin
                if (bus.pt_idx == 5'(i)) begin
                    mask_d[shadow][i]  = 1'b1;
                    coord_d[shadow][i] = {bus.pt_y, bus.pt_x};
                end
            end
        end

        if (do_swap) begin
            vis_sel_d     = ~vis_sel_q;
            frame_count_d = frame_count_q + 16'd1;
        end

        // Start together with end: close the frame first, then open a fresh one
        if (do_end && bus.pt_frame_start) begin
            if (do_swap) mask_d[vis_sel_q] = '0;
            else         mask_d[shadow]    = '0;
        end

        sticky_set[0] = bus.pt_valid && !capturing && !bus.pt_frame_start;
        sticky_set[1] = bus.pt_valid && !in_range && (capturing || bus.pt_frame_start);
        sticky_set[2] = capturing && bus.pt_frame_start && !bus.pt_frame_end;
        sticky_set[3] = do_end && ctrl_q[0];
        sticky_d      = ctrl_q[1] ? 4'd0 : (sticky_q | sticky_set);

        unique case (state_q)
            StIdle:    if (bus.pt_frame_start) state_d = StCapture;
            StCapture: if (bus.pt_frame_end) begin
                state_d = bus.pt_frame_start ? StCapture : StIdle;
            end
            default:   state_d = StIdle;
        endcase

        frame_done_d = do_swap;

        vis_mask16                 = '0;
        vis_mask16[NUM_POINTS-1:0] = mask_q[vis_sel_q];
        read_data_d                = '0;
        if (bus.coords_ram_read_addr == 5'd30) begin
            read_data_d = {frame_count_q, vis_mask16};
        end else if (bus.coords_ram_read_addr == 5'd31) begin
            read_data_d = {24'd0, sticky_q, ctrl_q};
        end else begin
            for (int i = 0; i < NUM_POINTS; i++) begin
                if (bus.coords_ram_read_addr == 5'(i) && mask_q[vis_sel_q][i]) begin
                    read_data_d[31]           = 1'b1;
                    read_data_d[16 +: COORD_W] = coord_q[vis_sel_q][i][COORD_W +: COORD_W];
                    read_data_d[0 +: COORD_W]  = coord_q[vis_sel_q][i][0 +: COORD_W];
                end
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q       <= StIdle;
            vis_sel_q     <= 1'b0;
            mask_q[0]     <= '0;
            mask_q[1]     <= '0;
            frame_count_q <= '0;
            ctrl_q        <= '0;
            sticky_q      <= '0;
            read_data_q   <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            vis_sel_q     <= vis_sel_d;
            mask_q        <= mask_d;
            frame_count_q <= frame_count_d;
            ctrl_q        <= ctrl_d;
            sticky_q      <= sticky_d;
            read_data_q   <= read_data_d;
            frame_done_q  <= frame_done_d;
        end
    end

    always_ff @(posedge clk_clk) begin
        coord_q <= coord_d;
    end

    assign bus.coords_ram_read_data = read_data_q;
    assign bus.frame_done           = frame_done_q;
endmodule
